spike_rate_decoder: RTL and testbench

Output-side rate decoder for the spiking inference pipeline. It accumulates per-neuron spike counts from the crossbar's output spike vector over a programmable window of timesteps. It then selects the winning class by sequential argmax and presents the result on a valid/ready handshake. It is the decode counterpart to the front-end spike encoder: pixels are rate-encoded into spikes on the input side, and spike rates are decoded back into a class index here.

---
 rtl/spike_rate_decoder.sv | 195 +++++++++++++++++++
 tb/tb_spike_rate_decoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed spike-count accumulator with sequential argmax and result handshake
//
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : begin a decode window (sampled only in IDLE)
//   window_len      : number of valid timesteps in the window, latched with start
//   spikes_in       : one timestep of output spikes, bit i = neuron i
//   spikes_valid    : spikes_in carries a timestep this cycle
//   busy            : decoder is not idle
//   class_out       : winning neuron index (lowest index on ties)
//   class_count     : spike count of the winner
//   tie             : another neuron matched the winner's count
//   saturated       : some counter hit its ceiling during this window
//   result_valid    : result available, held until result_ready
//   result_ready    : consumer accepts the result
module spike_rate_decoder #(
    parameter int N_OUTPUTS = 10,
    parameter int CNT_WIDTH = 16,
    parameter int WIN_WIDTH = 16,
    localparam int IDX_W = (N_OUTPUTS > 1) ? $clog2(N_OUTPUTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIN_WIDTH-1:0] window_len,
    input  logic [N_OUTPUTS-1:0] spikes_in,
    input  logic                 spikes_valid,
    output logic                 busy,
    output logic [IDX_W-1:0]     class_out,
    output logic [CNT_WIDTH-1:0] class_count,
    output logic                 tie,
    output logic                 saturated,
    output logic                 result_valid,
    input  logic                 result_ready
);

    typedef enum logic [1:0] {IDLE, ACCUM, SCAN, HOLD} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUTPUTS - 1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q [N_OUTPUTS];
    logic [CNT_WIDTH-1:0]   cnt_d [N_OUTPUTS];
    logic [WIN_WIDTH-1:0]   remaining_q, remaining_d;
    logic [IDX_W-1:0]       scan_j_q, scan_j_d;
    logic [IDX_W-1:0]       best_idx_q, best_idx_d;
    logic [CNT_WIDTH-1:0]   best_cnt_q, best_cnt_d;
    logic                   best_tie_q, best_tie_d;
    logic                   busy_q, busy_d;
    logic [IDX_W-1:0]       class_out_q, class_out_d;
    logic [CNT_WIDTH-1:0]   class_count_q, class_count_d;
    logic                   tie_q, tie_d;
    logic                   saturated_q, saturated_d;
    logic                   result_valid_q, result_valid_d;

    // Running-best update for the neuron currently under scan.
    logic [CNT_WIDTH-1:0]   cur_cnt;
    logic [IDX_W-1:0]       nb_idx;
    logic [CNT_WIDTH-1:0]   nb_cnt;
    logic                   nb_tie;

    always_comb begin
        cur_cnt = cnt_q[scan_j_q];
        nb_idx  = best_idx_q;
        nb_cnt  = best_cnt_q;
        nb_tie  = best_tie_q;
        if (scan_j_q == '0) begin
            nb_idx = '0;
            nb_cnt = cur_cnt;
            nb_tie = 1'b0;
        end else if (cur_cnt > best_cnt_q) begin
            nb_idx = scan_j_q;
            nb_cnt = cur_cnt;
            nb_tie = 1'b0;
        end else if (cur_cnt == best_cnt_q) begin
            nb_tie = 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        remaining_d    = remaining_q;
        scan_j_d       = scan_j_q;
        best_idx_d     = best_idx_q;
        best_cnt_d     = best_cnt_q;
        best_tie_d     = best_tie_q;
        busy_d         = busy_q;
        class_out_d    = class_out_q;
        class_count_d  = class_count_q;
        tie_d          = tie_q;
        saturated_d    = saturated_q;
        result_valid_d = result_valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < N_OUTPUTS; i++) begin
                        cnt_d[i] = '0;
                    end
                    saturated_d = 1'b0;
                    remaining_d = window_len;
                    busy_d      = 1'b1;
                    scan_j_d    = '0;
                    // An empty window skips accumulation and scans all-zero counts.
                    state_d     = (window_len == '0) ? SCAN : ACCUM;
                end
            end
            ACCUM: begin
                if (spikes_valid) begin
                    for (int i = 0; i < N_OUTPUTS; i++) begin
                        if (spikes_in[i]) begin
                            if (cnt_q[i] == '1) begin
                                saturated_d = 1'b1;
                            end else begin
                                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                            end
                        end
                    end
                    remaining_d = remaining_q - WIN_WIDTH'(1);
                    if (remaining_q == WIN_WIDTH'(1)) begin
                        scan_j_d = '0;
                        state_d  = SCAN;
                    end
                end
            end
            SCAN: begin
                best_idx_d = nb_idx;
                best_cnt_d = nb_cnt;
                best_tie_d = nb_tie;
                scan_j_d   = scan_j_q + IDX_W'(1);
                if (scan_j_q == LAST_IDX) begin
                    class_out_d    = nb_idx;
                    class_count_d  = nb_cnt;
                    tie_d          = nb_tie;
                    result_valid_d = 1'b1;
                    scan_j_d       = '0;
                    state_d        = HOLD;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    busy_d         = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            for (int i = 0; i < N_OUTPUTS; i++) begin
                cnt_q[i] <= '0;
            end
            remaining_q    <= '0;
            scan_j_q       <= '0;
            best_idx_q     <= '0;
            best_cnt_q     <= '0;
            best_tie_q     <= 1'b0;
            busy_q         <= 1'b0;
            class_out_q    <= '0;
            class_count_q  <= '0;
            tie_q          <= 1'b0;
            saturated_q    <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            remaining_q    <= remaining_d;
            scan_j_q       <= scan_j_d;
            best_idx_q     <= best_idx_d;
            best_cnt_q     <= best_cnt_d;
            best_tie_q     <= best_tie_d;
            busy_q         <= busy_d;
            class_out_q    <= class_out_d;
            class_count_q  <= class_count_d;
            tie_q          <= tie_d;
            saturated_q    <= saturated_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign busy         = busy_q;
    assign class_out    = class_out_q;
    assign class_count  = class_count_q;
    assign tie          = tie_q;
    assign saturated    = saturated_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - table-driven bench for spike_rate_decoder
module tb_spike_rate_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] window_len;
    logic [9:0]  spikes_in;
    logic        spikes_valid;
    logic        result_ready;

    logic        busy, tie, saturated, result_valid;
    logic [3:0]  class_out;
    logic [15:0] class_count;

    logic        busy4, tie4, saturated4, result_valid4;
    logic [3:0]  class_out4;
    logic [3:0]  class_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spike_rate_decoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .window_len(window_len),
        .spikes_in(spikes_in), .spikes_valid(spikes_valid), .busy(busy),
        .class_out(class_out), .class_count(class_count), .tie(tie),
        .saturated(saturated), .result_valid(result_valid), .result_ready(result_ready)
    );

    spike_rate_decoder #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .window_len(window_len),
        .spikes_in(spikes_in), .spikes_valid(spikes_valid), .busy(busy4),
        .class_out(class_out4), .class_count(class_count4), .tie(tie4),
        .saturated(saturated4), .result_valid(result_valid4), .result_ready(result_ready)
    );

    typedef struct {
        logic [15:0] win;
        logic [9:0]  all_m;
        logic [9:0]  part_m;
        int          part_n;
        bit          gap;
        int          exp_cls;
        int          exp_cnt;
        bit          exp_tie;
        int          exp4_cnt;
        bit          exp4_sat;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one window up to the result; leaves the DUT in HOLD.
    task automatic run_to_result(input int k);
        vec_t v;
        int   n;
        v = vecs[k];
        // spikes while idle must not be counted
        spikes_valid = 1'b1;
        spikes_in    = '1;
        tick();
        tick();
        start      = 1'b1;
        window_len = v.win;
        tick();
        start = 1'b0;
        chk($sformatf("v%0d busy_after_start", k), int'(busy), 1);
        for (int s = 0; s < int'(v.win); s++) begin
            if (v.gap) begin
                spikes_valid = 1'b0;
                spikes_in    = '1;
                tick();
            end
            spikes_valid = 1'b1;
            spikes_in    = v.all_m | ((s < v.part_n) ? v.part_m : 10'd0);
            tick();
        end
        // noise after the window must be ignored during SCAN
        spikes_valid = 1'b1;
        spikes_in    = '1;
        n = 0;
        while (!result_valid && n < 40) begin
            tick();
            n++;
        end
        spikes_valid = 1'b0;
        spikes_in    = '0;
        chk($sformatf("v%0d latency", k), n, 10);
        chk($sformatf("v%0d class_out", k), int'(class_out), v.exp_cls);
        chk($sformatf("v%0d class_count", k), int'(class_count), v.exp_cnt);
        chk($sformatf("v%0d tie", k), int'(tie), int'(v.exp_tie));
        chk($sformatf("v%0d saturated", k), int'(saturated), 0);
        chk($sformatf("v%0d rv4", k), int'(result_valid4), 1);
        chk($sformatf("v%0d class_out4", k), int'(class_out4), v.exp_cls);
        chk($sformatf("v%0d class_count4", k), int'(class_count4), v.exp4_cnt);
        chk($sformatf("v%0d saturated4", k), int'(saturated4), int'(v.exp4_sat));
    endtask

    task automatic handshake(input int k);
        result_ready = 1'b1;
        start        = 1'b1;
        tick();
        result_ready = 1'b0;
        start        = 1'b0;
        chk($sformatf("v%0d rv_after_hs", k), int'(result_valid), 0);
        chk($sformatf("v%0d busy_after_hs", k), int'(busy), 0);
        chk($sformatf("v%0d class_kept", k), int'(class_count), vecs[k].exp_cnt);
        chk($sformatf("v%0d sat4_kept", k), int'(saturated4), int'(vecs[k].exp4_sat));
        tick();
        chk($sformatf("v%0d no_restart", k), int'(busy), 0);
    endtask

    initial begin
        //        win    all_m                   part_m               pn gap cls cnt tie c4  s4
        vecs[0] = '{16'd5,  10'b1 << 3,            10'b1 << 7,          2, 0, 3, 5,  0, 5,  0};
        vecs[1] = '{16'd4,  (10'b1 << 2) | (10'b1 << 6), 10'd0,         0, 0, 2, 4,  1, 4,  0};
        vecs[2] = '{16'd3,  10'b1 << 4,            10'b1 << 1,          2, 1, 4, 3,  0, 3,  0};
        vecs[3] = '{16'd0,  10'd0,                 10'd0,               0, 0, 0, 0,  1, 0,  0};
        vecs[4] = '{16'd20, 10'b1,                 10'd0,               0, 0, 0, 20, 0, 15, 1};
        vecs[5] = '{16'd6,  10'b1 << 8,            10'b1 << 1,          6, 0, 1, 6,  1, 6,  0};
        vecs[6] = '{16'd3,  10'b1 << 9,            10'b11,              2, 0, 9, 3,  0, 3,  0};

        rst_n = 1'b0; start = 1'b0; window_len = '0; spikes_in = '0;
        spikes_valid = 1'b0; result_ready = 1'b0;
        tick();
        tick();
        chk("rst busy", int'(busy), 0);
        chk("rst class_out", int'(class_out), 0);
        chk("rst class_count", int'(class_count), 0);
        chk("rst tie", int'(tie), 0);
        chk("rst saturated", int'(saturated), 0);
        chk("rst result_valid", int'(result_valid), 0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 7; k++) begin
            run_to_result(k);
            handshake(k);
        end

        // Hold with ready low while start and spikes_valid toggle.
        begin
            bit stable;
            run_to_result(0);
            stable = 1'b1;
            for (int c = 0; c < 20; c++) begin
                start        = c[0];
                window_len   = 16'd1;
                spikes_valid = ~c[0];
                spikes_in    = '1;
                tick();
                if (!(result_valid && busy && class_out == 4'd3 &&
                      class_count == 16'd5 && !tie))
                    stable = 1'b0;
            end
            start = 1'b0; spikes_valid = 1'b0; spikes_in = '0;
            chk("hold stable", int'(stable), 1);
            handshake(0);
        end

        // Reset mid-ACCUM, then a fresh window must start from zero.
        begin
            start = 1'b1; window_len = 16'd5;
            tick();
            start = 1'b0;
            spikes_valid = 1'b1; spikes_in = 10'b1 << 5;
            tick();
            tick();
            spikes_valid = 1'b0; spikes_in = '0;
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            chk("midrst busy", int'(busy), 0);
            chk("midrst result_valid", int'(result_valid), 0);
            chk("midrst class_count", int'(class_count), 0);
            tick();
            chk("midrst stays idle", int'(busy), 0);
            vecs[0] = '{16'd2, 10'b1 << 5, 10'd0, 0, 0, 5, 2, 0, 2, 0};
            run_to_result(0);
            handshake(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
